// File: rtl/alu_operand_stage_if.sv
// Operand-stage bus: register-file write port, request side and ALU operand side.
interface alu_operand_stage_if;
  localparam int unsigned W    = 16;
  localparam int unsigned IDXW = 3;

  logic            write;
  logic [IDXW-1:0] writenum;
  logic [W-1:0]    data_in;

  logic            req_valid;
  logic            req_ready;
  logic [IDXW-1:0] rn;
  logic [IDXW-1:0] rm;
  logic [1:0]      shift;
  logic            asel;
  logic            bsel;
  logic [W-1:0]    imm;
  logic [1:0]      aluop_in;

  logic [W-1:0]    Ain;
  logic [W-1:0]    Bin;
  logic [1:0]      ALUop;
  logic            op_valid;
  logic            op_ready;

  modport master (
    output write, writenum, data_in,
    output req_valid, rn, rm, shift, asel, bsel, imm, aluop_in,
    output op_ready,
    input  req_ready, Ain, Bin, ALUop, op_valid
  );

  modport slave (
    input  write, writenum, data_in,
    input  req_valid, rn, rm, shift, asel, bsel, imm, aluop_in,
    input  op_ready,
    output req_ready, Ain, Bin, ALUop, op_valid
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ALU operand stage: 8x16 register file, A/B latches, B shifter and source muxes,
// presenting registered Ain/Bin/ALUop under a valid/ready handshake.
module alu_operand_stage #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned W     = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  alu_operand_stage_if.slave  bus
);
  localparam int unsigned IDXW = $clog2(NREGS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ_A  = 2'd1,
    S_READ_B  = 2'd2,
    S_PRESENT = 2'd3
  } state_t;

  typedef struct packed {
    logic [IDXW-1:0] rm;
    logic [1:0]      shift;
    logic            asel;
    logic            bsel;
    logic [W-1:0]    imm;
    logic [1:0]      aluop;
  } req_t;

  state_t       state_q, state_d;
  req_t         cap_q, cap_d;
  logic [W-1:0] regs_q [NREGS];
  logic [W-1:0] regs_d [NREGS];
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] ain_q, ain_d;
  logic [W-1:0] bin_q, bin_d;
  logic [1:0]   aluop_q, aluop_d;
  logic         op_valid_q, op_valid_d;
  logic         req_ready_q, req_ready_d;

  function automatic logic [W-1:0] shift_b(input logic [1:0] sh, input logic [W-1:0] b);
    unique case (sh)
      2'b01:   shift_b = {b[W-2:0], 1'b0};
      2'b10:   shift_b = {1'b0, b[W-1:1]};
      2'b11:   shift_b = {b[W-1], b[W-1:1]};
      default: shift_b = b;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; requests are only sampled in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (bus.req_valid) state_d = S_READ_A;
      S_READ_A:  state_d = S_READ_B;
      S_READ_B:  state_d = S_PRESENT;
      S_PRESENT: if (bus.op_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values per state
  always_comb begin
    cap_d      = cap_q;
    a_d        = a_q;
    b_d        = b_q;
    ain_d      = ain_q;
    bin_d      = bin_q;
    aluop_d    = aluop_q;
    op_valid_d = op_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          cap_d.rm    = bus.rm;
          cap_d.shift = bus.shift;
          cap_d.asel  = bus.asel;
          cap_d.bsel  = bus.bsel;
          cap_d.imm   = bus.imm;
          cap_d.aluop = bus.aluop_in;
          a_d         = regs_q[bus.rn];
        end
      end
      S_READ_A: b_d = regs_q[cap_q.rm];
      S_READ_B: begin
        ain_d      = cap_q.asel ? '0 : a_q;
        bin_d      = cap_q.bsel ? cap_q.imm : shift_b(cap_q.shift, b_q);
        aluop_d    = cap_q.aluop;
        op_valid_d = 1'b1;
      end
      S_PRESENT: if (bus.op_ready) op_valid_d = 1'b0;
      default: ;
    endcase
    req_ready_d = (state_d == S_IDLE);
  end

  // Write port; reads above see the pre-edge contents
  always_comb begin
    regs_d = regs_q;
    if (bus.write) regs_d[bus.writenum] = bus.data_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q      <= '{default: '0};
      cap_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ain_q       <= '0;
      bin_q       <= '0;
      aluop_q     <= 2'b00;
      op_valid_q  <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      regs_q      <= regs_d;
      cap_q       <= cap_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ain_q       <= ain_d;
      bin_q       <= bin_d;
      aluop_q     <= aluop_d;
      op_valid_q  <= op_valid_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign bus.Ain       = ain_q;
  assign bus.Bin       = bin_q;
  assign bus.ALUop     = aluop_q;
  assign bus.op_valid  = op_valid_q;
  assign bus.req_ready = req_ready_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with a cycle-level reference model and literal checks.
module tb_alu_operand_stage;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  alu_operand_stage_if bus ();
  alu_operand_stage dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: remembers the request, reads B one cycle later, result one cycle after that
  logic [15:0] m_regs [8];
  bit          busy, m_valid;
  int          age;
  logic [2:0]  c_rm;
  logic [1:0]  c_shift, c_op, m_op;
  logic        c_asel, c_bsel;
  logic [15:0] c_imm, m_a, m_b, m_ain, m_bin;

  function automatic logic [15:0] shf(input logic [1:0] s, input logic [15:0] b);
    case (s)
      2'd0:    return b;
      2'd1:    return b << 1;
      2'd2:    return b >> 1;
      default: return 16'($signed(b) >>> 1);
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) m_regs[i] <= 16'h0;
      busy <= 1'b0; m_valid <= 1'b0; age <= 0;
      m_ain <= 16'h0; m_bin <= 16'h0; m_op <= 2'b00;
    end else begin
      if (m_valid) begin
        if (bus.op_ready) begin m_valid <= 1'b0; busy <= 1'b0; end
      end else if (busy) begin
        age <= age + 1;
        if (age == 0) m_b <= m_regs[c_rm];
        else if (age == 1) begin
          m_ain   <= c_asel ? 16'h0 : m_a;
          m_bin   <= c_bsel ? c_imm : shf(c_shift, m_b);
          m_op    <= c_op;
          m_valid <= 1'b1;
        end
      end else if (bus.req_valid) begin
        busy <= 1'b1; age <= 0;
        c_rm <= bus.rm; c_shift <= bus.shift; c_asel <= bus.asel;
        c_bsel <= bus.bsel; c_imm <= bus.imm; c_op <= bus.aluop_in;
        m_a <= m_regs[bus.rn];
      end
      if (bus.write) m_regs[bus.writenum] <= bus.data_in;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("model_op_valid", 32'(bus.op_valid), 32'(m_valid));
      check("model_req_ready", 32'(bus.req_ready), 32'(!busy));
      if (m_valid) begin
        check("model_Ain", 32'(bus.Ain), 32'(m_ain));
        check("model_Bin", 32'(bus.Bin), 32'(m_bin));
        check("model_ALUop", 32'(bus.ALUop), 32'(m_op));
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [15:0] val);
    bus.write = 1'b1; bus.writenum = idx; bus.data_in = val;
    step();
    bus.write = 1'b0;
  endtask

  task automatic req_start(input logic [2:0] rn, input logic [2:0] rm, input logic [1:0] sh,
                           input logic asel, input logic bsel, input logic [15:0] imm,
                           input logic [1:0] op);
    bus.rn = rn; bus.rm = rm; bus.shift = sh; bus.asel = asel; bus.bsel = bsel;
    bus.imm = imm; bus.aluop_in = op; bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                          input logic [1:0] eop);
    step();
    bus.write = 1'b0;
    check({tag, "_early_valid"}, 32'(bus.op_valid), 32'd0);
    step();
    check({tag, "_op_valid"}, 32'(bus.op_valid), 32'd1);
    check({tag, "_Ain"}, 32'(bus.Ain), 32'(ea));
    check({tag, "_Bin"}, 32'(bus.Bin), 32'(eb));
    check({tag, "_ALUop"}, 32'(bus.ALUop), 32'(eop));
  endtask

  task automatic handshake(input string tag);
    bus.op_ready = 1'b1;
    step();
    bus.op_ready = 1'b0;
    check({tag, "_hs_valid"}, 32'(bus.op_valid), 32'd0);
    check({tag, "_hs_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic full_req(input string tag, input logic [2:0] rn, input logic [2:0] rm,
                          input logic [1:0] sh, input logic asel, input logic bsel,
                          input logic [15:0] imm, input logic [1:0] op,
                          input logic [15:0] ea, input logic [15:0] eb);
    req_start(rn, rm, sh, asel, bsel, imm, op);
    wait_out(tag, ea, eb, op);
    handshake(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] shexp [4];
    shexp[0] = 16'hFFFD; shexp[1] = 16'hFFFA; shexp[2] = 16'h7FFE; shexp[3] = 16'hFFFE;

    reset_n = 1'b0;
    bus.write = 1'b0; bus.writenum = '0; bus.data_in = '0;
    bus.req_valid = 1'b0; bus.rn = '0; bus.rm = '0; bus.shift = '0;
    bus.asel = 1'b0; bus.bsel = 1'b0; bus.imm = '0; bus.aluop_in = '0; bus.op_ready = 1'b0;
    #12;
    check("rst_op_valid", 32'(bus.op_valid), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_Ain", 32'(bus.Ain), 32'd0);
    check("rst_Bin", 32'(bus.Bin), 32'd0);
    check("rst_ALUop", 32'(bus.ALUop), 32'd0);
    step();
    reset_n = 1'b1;
    step();

    // Basic add operands, then each ALU op
    wr(3'd1, 16'd13);
    wr(3'd2, 16'd10);
    full_req("t1_add", 3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00, 16'h000D, 16'h000A);
    full_req("t1_sub", 3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0, 2'b01, 16'h000D, 16'h000A);
    full_req("t1_and", 3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0, 2'b10, 16'h000D, 16'h000A);
    full_req("t1_notb", 3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0, 2'b11, 16'h000D, 16'h000A);

    // Shifter on a negative value
    wr(3'd3, 16'hFFFD);
    for (int s = 0; s < 4; s++)
      full_req($sformatf("t2_shift%0d", s), 3'd1, 3'd3, 2'(s), 1'b0, 1'b0, 16'h0, 2'b00,
               16'h000D, shexp[s]);

    // Zero A and immediate B
    full_req("t3_imm", 3'd1, 3'd2, 2'b01, 1'b1, 1'b1, 16'h0005, 2'b00, 16'h0000, 16'h0005);

    // Back-pressure with noisy inputs
    req_start(3'd2, 3'd1, 2'b00, 1'b0, 1'b0, 16'h0, 2'b10);
    wait_out("t4", 16'h000A, 16'h000D, 2'b10);
    for (int i = 0; i < 10; i++) begin
      bus.req_valid = ~bus.req_valid; bus.rn = 3'(i); bus.rm = 3'(7 - i);
      bus.imm = 16'(i * 77); bus.aluop_in = 2'(i); bus.asel = ~bus.asel;
      step();
      check("t4_hold_valid", 32'(bus.op_valid), 32'd1);
      check("t4_hold_ready", 32'(bus.req_ready), 32'd0);
      check("t4_hold_Ain", 32'(bus.Ain), 32'h000A);
      check("t4_hold_Bin", 32'(bus.Bin), 32'h000D);
      check("t4_hold_ALUop", 32'(bus.ALUop), 32'd2);
    end
    bus.req_valid = 1'b0; bus.asel = 1'b0;
    handshake("t4");

    // Write during READ_A does not disturb the in-flight B read
    req_start(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00);
    bus.write = 1'b1; bus.writenum = 3'd2; bus.data_in = 16'd99;
    wait_out("t5_old", 16'h000D, 16'h000A, 2'b00);
    handshake("t5_old");
    full_req("t5_new", 3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00, 16'h000D, 16'h0063);

    // Asynchronous reset during READ_B
    req_start(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0, 2'b01);
    step();
    #1;
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus.op_valid), 32'd0);
    check("t6_rst_ready", 32'(bus.req_ready), 32'd1);
    check("t6_rst_Ain", 32'(bus.Ain), 32'd0);
    check("t6_rst_Bin", 32'(bus.Bin), 32'd0);
    check("t6_rst_ALUop", 32'(bus.ALUop), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    check("t6_post_ready", 32'(bus.req_ready), 32'd1);
    check("t6_post_valid", 32'(bus.op_valid), 32'd0);
    full_req("t6_r1", 3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0, 2'b01, 16'h0000, 16'h0000);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
